// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrating multiplexer slice: arbitration
// mode encodings and the derived index-width helper.
package arb_pkg;

    // Arbitration policy selected by the MODE parameter of the top.
    typedef enum int unsigned {
        ARB_FIXED = 0,
        ARB_RR    = 1
    } arb_mode_e;

    // Width needed to number n channels; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/priority_find_first.sv
// Lowest-index-first search over a request vector: reports whether any
// bit is set and the index of the lowest set bit.
module priority_find_first
    import arb_pkg::*;
#(
    parameter int unsigned INPUTS = 4,
    parameter int unsigned IDXW   = idx_width(INPUTS)
) (
    input  logic [INPUTS-1:0] req,
    output logic              found,
    output logic [IDXW-1:0]   idx
);

    // Scan from the top down so lower indices overwrite higher ones.
    always_comb begin
        found = |req;
        idx   = '0;
        for (int unsigned i = INPUTS; i > 0; i--) begin
            if (req[i-1]) begin
                idx = IDXW'(i - 1);
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_mux.sv
// Registered, handshaked N:1 arbitrating multiplexer. Picks one valid
// stream by fixed priority or round-robin, holds the grant for the whole
// packet, and presents the winning beat through a one-deep output stage.
module priority_arbiter_mux
    import arb_pkg::*;
#(
    parameter int unsigned INPUTS = 4,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MODE   = ARB_FIXED,
    parameter int unsigned IDXW   = idx_width(INPUTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [INPUTS-1:0]            in_valid,
    input  logic [INPUTS-1:0]            in_last,
    input  logic [INPUTS-1:0][WIDTH-1:0] in_data,
    output logic [INPUTS-1:0]            in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_last,
    output logic [IDXW-1:0]              out_idx,
    input  logic                         out_ready
);

    logic             load;
    logic             transfer;
    logic             grant_valid;
    logic [IDXW-1:0]  grant;
    logic             free_found;
    logic [IDXW-1:0]  free_idx;
    logic             lock;
    logic [IDXW-1:0]  lock_idx;
    logic [IDXW-1:0]  rr_ptr;
    logic [IDXW-1:0]  rr_next;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    // Candidate winner when no packet is in progress.
    if (MODE == ARB_RR) begin : g_rr
        logic [INPUTS-1:0] rr_mask;
        logic [INPUTS-1:0] masked_req;
        logic              m_found;
        logic              u_found;
        logic [IDXW-1:0]   m_idx;
        logic [IDXW-1:0]   u_idx;

        // Channels at or above the pointer get first chance; the unmasked
        // search covers the wrap back to channel 0.
        always_comb begin
            rr_mask    = {INPUTS{1'b1}} << rr_ptr;
            masked_req = in_valid & rr_mask;
        end

        priority_find_first #(
            .INPUTS (INPUTS),
            .IDXW   (IDXW)
        ) u_find_masked (
            .req    (masked_req),
            .found  (m_found),
            .idx    (m_idx)
        );

        priority_find_first #(
            .INPUTS (INPUTS),
            .IDXW   (IDXW)
        ) u_find_all (
            .req    (in_valid),
            .found  (u_found),
            .idx    (u_idx)
        );

        // Prefer the masked winner; fall back to the wrapped search.
        always_comb begin
            free_found = u_found;
            free_idx   = m_found ? m_idx : u_idx;
        end
    end else begin : g_fixed
        priority_find_first #(
            .INPUTS (INPUTS),
            .IDXW   (IDXW)
        ) u_find (
            .req    (in_valid),
            .found  (free_found),
            .idx    (free_idx)
        );
    end

    // A locked packet owns the port even while its channel idles, which
    // produces a bubble rather than letting another channel in.
    always_comb begin
        grant       = free_idx;
        grant_valid = free_found;
        if (lock) begin
            grant       = lock_idx;
            grant_valid = 1'b0;
            for (int unsigned k = 0; k < INPUTS; k++) begin
                if (lock_idx == IDXW'(k)) begin
                    grant_valid = in_valid[k];
                end
            end
        end
    end

    // Stage enable, per-channel accept and the granted beat's payload.
    always_comb begin
        load     = !out_valid || out_ready;
        transfer = load && grant_valid;
        in_ready = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int unsigned k = 0; k < INPUTS; k++) begin
            if (grant == IDXW'(k)) begin
                in_ready[k] = transfer;
                sel_data    = in_data[k];
                sel_last    = in_last[k];
            end
        end
        rr_next = (grant == IDXW'(INPUTS - 1)) ? '0 : grant + IDXW'(1);
    end

    // Output register stage: load on transfer, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_idx   <= '0;
        end else begin
            out_valid <= transfer || (out_valid && !out_ready);
            if (transfer) begin
                out_data <= sel_data;
                out_last <= sel_last;
                out_idx  <= grant;
            end
        end
    end

    // Packet lock and round-robin pointer, both advanced only on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock     <= 1'b0;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else if (transfer) begin
            if (sel_last) begin
                lock   <= 1'b0;
                rr_ptr <= rr_next;
            end else begin
                lock     <= 1'b1;
                lock_idx <= grant;
            end
        end
    end

endmodule
